// File: rtl/lint_serial_deser.sv
// Serial-to-parallel deserializer: SOF beat, DATA_W data beats LSB first, optional even-parity beat.
// Word is held with out_valid until out_ready; input is stalled (in_ready=0) while a word is held.
module lint_serial_deser #(
  parameter int DATA_W    = 8,
  parameter int PARITY_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic              in_bit,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_perr,
  output logic              out_abort,
  output logic [7:0]        out_frames
);

  localparam int CW = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, HOLD} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     count;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] word;
  logic              accept;
  logic              start;
  logic              restart;
  logic              data_beat;
  logic              last_data;
  logic              par_beat;
  logic              handshake;
  logic              load_out;

  always_comb begin
    in_ready  = (state != HOLD);
    out_valid = (state == HOLD);
    accept    = in_valid && in_ready;
    start     = accept && in_sof;
    restart   = start && (state == DATA || state == PARITY);
    data_beat = accept && !in_sof && (state == DATA);
    last_data = data_beat && (count == CW'(DATA_W - 1));
    par_beat  = accept && !in_sof && (state == PARITY);
    handshake = out_valid && out_ready;

    // Shift register with the current beat merged in, so the final data beat can load out_data directly.
    word = shreg;
    for (int i = 0; i < DATA_W; i++) begin
      if (data_beat && count == CW'(i)) begin
        word[i] = in_bit;
      end
    end

    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = DATA;
      end
      DATA: begin
        if (start) begin
          state_nxt = DATA;
        end else if (last_data) begin
          state_nxt = (PARITY_EN != 0) ? PARITY : HOLD;
        end
      end
      PARITY: begin
        if (start) begin
          state_nxt = DATA;
        end else if (par_beat) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (handshake) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    load_out = (state != HOLD) && (state_nxt == HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      shreg      <= '0;
      out_data   <= '0;
      out_perr   <= 1'b0;
      out_abort  <= 1'b0;
      out_frames <= 8'd0;
    end else begin
      state     <= state_nxt;
      out_abort <= restart;
      if (start && state != HOLD) begin
        count <= '0;
        shreg <= '0;
      end else if (data_beat) begin
        count <= count + 1'b1;
        shreg <= word;
      end
      // Output word only changes when a new word is presented.
      if (load_out) begin
        out_data <= word;
        out_perr <= (PARITY_EN != 0) && (^shreg ^ in_bit);
      end
      if (handshake) begin
        out_frames <= out_frames + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_lint_serial_deser.sv
// Randomized self-checking bench: frame-level model (bit lists, XOR parity, frame counter) vs two DUT configurations.
module tb_lint_serial_deser;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_sof, in_bit, in_ready;
  logic       out_valid, out_ready, out_perr, out_abort;
  logic [7:0] out_data, out_frames;

  logic       in_valid4, in_sof4, in_bit4, in_ready4;
  logic       out_valid4, out_ready4, out_perr4, out_abort4;
  logic [3:0] out_data4;
  logic [7:0] out_frames4;

  int errors = 0;
  int checks = 0;
  int exp_frames = 0;
  bit in_frame = 1'b0;
  int nbits = 0;

  always #5 clk = ~clk;

  lint_serial_deser #(.DATA_W(8), .PARITY_EN(1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_bit(in_bit),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_perr(out_perr), .out_abort(out_abort), .out_frames(out_frames)
  );

  lint_serial_deser #(.DATA_W(4), .PARITY_EN(0)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_sof(in_sof4), .in_bit(in_bit4),
    .in_ready(in_ready4), .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
    .out_perr(out_perr4), .out_abort(out_abort4), .out_frames(out_frames4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One accepted beat; the model predicts whether this beat restarts a frame in progress.
  task automatic send_beat(input logic sof, input logic b);
    logic exp_ab;
    exp_ab = 1'b0;
    if (sof) begin
      exp_ab   = in_frame;
      in_frame = 1'b1;
      nbits    = 0;
    end else if (in_frame) begin
      nbits++;
      if (nbits == 9) in_frame = 1'b0;
    end
    in_valid = 1'b1;
    in_sof   = sof;
    in_bit   = b;
    @(negedge clk);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_bit   = 1'b0;
    chk("abort", 32'(out_abort), 32'(exp_ab));
  endtask

  task automatic gap();
    if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
  endtask

  task automatic do_frame(input int npre, input logic [7:0] d, input bit par_ok);
    logic p;
    int   nh;
    repeat ($urandom_range(0, 2)) send_beat(1'b0, 1'($urandom_range(0, 1)));
    if (npre > 0) begin
      send_beat(1'b1, 1'b0);
      for (int i = 0; i < npre; i++) begin
        gap();
        send_beat(1'b0, 1'($urandom_range(0, 1)));
      end
    end
    send_beat(1'b1, 1'($urandom_range(0, 1)));
    for (int i = 0; i < 8; i++) begin
      gap();
      send_beat(1'b0, d[i]);
    end
    p = (^d) ^ !par_ok;
    gap();
    send_beat(1'b0, p);
    chk("valid_rise", 32'(out_valid), 32'd1);
    chk("data", 32'(out_data), 32'(d));
    chk("perr", 32'(out_perr), 32'(!par_ok));
    nh = $urandom_range(0, 5);
    for (int i = 0; i < nh; i++) begin
      in_valid = 1'b1;
      in_sof   = 1'($urandom_range(0, 1));
      in_bit   = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("hold_ready", 32'(in_ready), 32'd0);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_data", 32'(out_data), 32'(d));
      chk("hold_abort", 32'(out_abort), 32'd0);
    end
    // SOF offered during the handshake cycle must be ignored.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_sof    = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    exp_frames = (exp_frames + 1) % 256;
    chk("valid_drop", 32'(out_valid), 32'd0);
    chk("frames", 32'(out_frames), exp_frames);
    chk("data_keep", 32'(out_data), 32'(d));
    chk("ready_idle", 32'(in_ready), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_data"}, 32'(out_data), 32'd0);
    chk({tag, "_perr"}, 32'(out_perr), 32'd0);
    chk({tag, "_abort"}, 32'(out_abort), 32'd0);
    chk({tag, "_frames"}, 32'(out_frames), 32'd0);
  endtask

  task automatic frame4(input logic [3:0] n);
    in_valid4 = 1'b1;
    in_sof4   = 1'b1;
    in_bit4   = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      in_sof4 = 1'b0;
      in_bit4 = n[i];
      @(negedge clk);
    end
    in_valid4 = 1'b0;
    chk("w4_valid", 32'(out_valid4), 32'd1);
    chk("w4_data", 32'(out_data4), 32'(n));
    chk("w4_perr", 32'(out_perr4), 32'd0);
    out_ready4 = 1'b1;
    @(negedge clk);
    out_ready4 = 1'b0;
    chk("w4_drop", 32'(out_valid4), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_sof = 1'b0; in_bit = 1'b0; out_ready = 1'b0;
    in_valid4 = 1'b0; in_sof4 = 1'b0; in_bit4 = 1'b0; out_ready4 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("reset");

    do_frame(0, 8'h0D, 1'b1);
    do_frame(0, 8'h0D, 1'b0);
    do_frame(3, 8'hA5, 1'b1);
    for (int f = 0; f < 256; f++) begin
      do_frame(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0,
               8'($urandom), 1'($urandom_range(0, 1)));
    end

    // Reset mid-frame, with a beat presented in the same cycle.
    send_beat(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) send_beat(1'b0, 1'($urandom_range(0, 1)));
    rst = 1'b1; in_valid = 1'b1; in_sof = 1'b0; in_bit = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
    in_frame = 1'b0; exp_frames = 0;
    check_reset_outputs("rst_mid");
    do_frame(0, 8'($urandom), 1'b1);

    // Reset wins over a pending handshake.
    send_beat(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) send_beat(1'b0, 1'b1);
    send_beat(1'b0, 1'b0);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    rst = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b0;
    exp_frames = 0;
    check_reset_outputs("rst_hold");

    frame4(4'hB);
    for (int i = 0; i < 4; i++) frame4(4'($urandom));
    chk("w4_frames", 32'(out_frames4), 32'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lint_serial_deser.md
LINT_SERIAL_DESER -- requirements
Module: lint_serial_deser

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning data bits per frame (legal range 1..16).
REQ-002 SHALL have parameter PARITY_EN, default 1, meaning 1 expects one even-parity beat after the data, 0 means no parity beat.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its posedge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1, serial beat present.
REQ-006 SHALL have port in_sof, input, 1, start-of-frame marker; this beat carries no data.
REQ-007 SHALL have port in_bit, input, 1, serial data or parity bit.
REQ-008 SHALL have port in_ready, output, 1, deserializer can accept a beat.
REQ-009 SHALL have port out_valid, output, 1, assembled word available.
REQ-010 SHALL have port out_ready, input, 1, downstream accepts the word.
REQ-011 SHALL have port out_data, output, DATA_W, assembled word, LSB received first.
REQ-012 SHALL have port out_perr, output, 1, parity error flag for out_data; forced 0 when PARITY_EN=0.
REQ-013 SHALL have port out_abort, output, 1, one-cycle pulse when a frame in progress is restarted.
REQ-014 SHALL have port out_frames, output, 8, count of completed output handshakes.

Function
REQ-015 SHALL accept a beat only when in_valid && in_ready at a clk posedge.
REQ-016 SHALL implement four states: IDLE, DATA, PARITY, HOLD.
REQ-017 SHALL drive in_ready=1 in IDLE, DATA and PARITY, and in_ready=0 in HOLD; in_ready is combinational from state only.
REQ-018 IDLE: SHALL ignore accepted beats with in_sof=0; an accepted beat with in_sof=1 SHALL clear the bit counter and shift register and go to DATA.
REQ-019 DATA: each accepted beat with in_sof=0 SHALL write in_bit to shift-register position count and increment count.
REQ-020 DATA: the beat that makes count reach DATA_W SHALL go to PARITY if PARITY_EN=1, else to HOLD.
REQ-021 PARITY: an accepted beat with in_sof=0 SHALL set out_perr = XOR of the DATA_W data bits XOR in_bit (0 means even total) and go to HOLD.
REQ-022 An accepted beat with in_sof=1 in DATA or PARITY SHALL restart the frame (count=0, register cleared, stay in or return to DATA) and pulse out_abort high for exactly the next cycle.
REQ-023 HOLD: SHALL hold out_valid=1, with out_data and out_perr stable, until out_ready=1.
REQ-024 On out_valid && out_ready: SHALL enter IDLE next cycle, drop out_valid, and increment out_frames modulo 256 (255 wraps to 0).
REQ-025 Latency: out_valid SHALL rise in the cycle after the last data or parity beat is accepted; minimum frame cost is 1+DATA_W+PARITY_EN beats plus 1 handshake cycle.
REQ-026 Idle cycles (in_valid=0) inside a frame SHALL NOT alter state or count.
REQ-027 In HOLD, in_valid, in_sof and in_bit SHALL have no effect, including in the handshake cycle itself; no same-cycle frame start.
REQ-028 out_data and out_perr SHALL keep their last values after the handshake until the next word is presented.

Reset
REQ-029 rst=1 at a posedge SHALL force IDLE, count=0, out_valid=0, out_data=0, out_perr=0, out_abort=0 and out_frames=0.
REQ-030 rst SHALL take priority over every other event, including a mid-frame beat or a pending handshake; a partial frame is discarded without an out_abort pulse.

Verification
REQ-031 DATA_W=8, PARITY_EN=1: sof, then bits 1,0,1,1,0,0,0,0, then parity 1 -> out_valid one cycle after the parity beat, out_data=8'h0D, out_perr=0, out_frames=1 after handshake.
REQ-032 Same frame with parity 0 -> out_data=8'h0D, out_perr=1.
REQ-033 sof, 3 data beats, sof, 8 beats giving 8'hA5, correct parity -> out_abort high for 1 cycle after the second sof, out_data=8'hA5, out_perr=0.
REQ-034 Word presented with out_ready=0 for 5 cycles while in_valid=1, in_sof=1 -> out_data is stable, in_ready=0, no abort; out_ready=1 -> IDLE next cycle.
REQ-035 256 back-to-back frames -> out_frames wraps 255 -> 0; rst asserted after 4 data beats -> all outputs 0 and the next sof starts a clean frame.
REQ-036 PARITY_EN=0, DATA_W=4: sof, bits 1,1,0,1 -> out_data=4'hB after 4 data beats, out_perr=0.
